// File: rtl/cpu_wb_regfile.sv
// Write-back register file: 32x32 GPRs, debug write port, 1-entry pending buffer, retire counter.
// Optional WB_BYPASS_EN: same-cycle live pipeline write forwarded to the read ports.
module cpu_wb_regfile #(
    parameter int NREG  = 32,
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             reg_write_en,
    input  logic [4:0]       reg_write_num,
    input  logic [DW-1:0]    reg_write_data,
    input  logic [4:0]       rs_num,
    input  logic [4:0]       rt_num,
    output logic [DW-1:0]    rs_data,
    output logic [DW-1:0]    rt_data,
    input  logic             dbg_wr,
    input  logic [4:0]       dbg_num,
    input  logic [DW-1:0]    dbg_data,
    output logic             pend_valid,
    output logic             ovf,
    output logic [CNT_W-1:0] retire_cnt
);

    logic [DW-1:0] regs [NREG];

    logic [4:0]    pend_num;
    logic [DW-1:0] pend_data;

    logic          live_we;
    logic          wr_en;
    logic [4:0]    wr_num;
    logic [DW-1:0] wr_data;
    logic          cnt_inc;
    logic          pend_load;
    logic          pend_clear;
    logic          ovf_set;

    // Writes to r0 are dropped outright, so they never pend, overflow or retire.
    assign live_we = reg_write_en && (reg_write_num != 5'd0);

    always_comb begin
        wr_en      = 1'b0;
        wr_num     = '0;
        wr_data    = '0;
        cnt_inc    = 1'b0;
        pend_load  = 1'b0;
        pend_clear = 1'b0;
        ovf_set    = 1'b0;
        if (dbg_wr) begin
            wr_en   = (dbg_num != 5'd0);
            wr_num  = dbg_num;
            wr_data = dbg_data;
            if (live_we) begin
                if (!pend_valid) begin
                    pend_load = 1'b1;
                end else begin
                    ovf_set = 1'b1;
                end
            end
        end else if (pend_valid) begin
            wr_en   = 1'b1;
            wr_num  = pend_num;
            wr_data = pend_data;
            cnt_inc = 1'b1;
            if (live_we) begin
                pend_load = 1'b1;
            end else begin
                pend_clear = 1'b1;
            end
        end else if (live_we) begin
            wr_en   = 1'b1;
            wr_num  = reg_write_num;
            wr_data = reg_write_data;
            cnt_inc = 1'b1;
        end
    end

    // wr_num is never 0 when wr_en is set, so regs[0] stays at its reset value.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_num] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pend_valid <= 1'b0;
            pend_num   <= '0;
            pend_data  <= '0;
        end else if (pend_load) begin
            pend_valid <= 1'b1;
            pend_num   <= reg_write_num;
            pend_data  <= reg_write_data;
        end else if (pend_clear) begin
            pend_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ovf        <= 1'b0;
            retire_cnt <= '0;
        end else begin
            if (ovf_set) begin
                ovf <= 1'b1;
            end
            if (cnt_inc) begin
                retire_cnt <= retire_cnt + 1'b1;
            end
        end
    end

    // Pending entry shadows the array, so a parked write is never read stale.
    always_comb begin
        rs_data = '0;
        if (rs_num != 5'd0) begin
            if (pend_valid && (pend_num == rs_num)) begin
                rs_data = pend_data;
            end else begin
                rs_data = regs[rs_num];
            end
`ifdef WB_BYPASS_EN
            if (reg_write_en && (reg_write_num == rs_num)) begin
                rs_data = reg_write_data;
            end
`endif
        end
    end

    always_comb begin
        rt_data = '0;
        if (rt_num != 5'd0) begin
            if (pend_valid && (pend_num == rt_num)) begin
                rt_data = pend_data;
            end else begin
                rt_data = regs[rt_num];
            end
`ifdef WB_BYPASS_EN
            if (reg_write_en && (reg_write_num == rt_num)) begin
                rt_data = reg_write_data;
            end
`endif
        end
    end

endmodule

// File: tb/tb_cpu_wb_regfile.sv
// Self-checking bench for cpu_wb_regfile: directed scenarios plus randomized traffic
// against an architectural model (register map, parked-write queue, counters).
module tb_cpu_wb_regfile;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        reg_write_en;
    logic [4:0]  reg_write_num;
    logic [31:0] reg_write_data;
    logic [4:0]  rs_num;
    logic [4:0]  rt_num;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        dbg_wr;
    logic [4:0]  dbg_num;
    logic [31:0] dbg_data;
    logic        pend_valid;
    logic        ovf;
    logic [15:0] retire_cnt;

    always #5 clk = ~clk;

    cpu_wb_regfile dut (
        .clk(clk), .clr_n(clr_n),
        .reg_write_en(reg_write_en), .reg_write_num(reg_write_num), .reg_write_data(reg_write_data),
        .rs_num(rs_num), .rt_num(rt_num), .rs_data(rs_data), .rt_data(rt_data),
        .dbg_wr(dbg_wr), .dbg_num(dbg_num), .dbg_data(dbg_data),
        .pend_valid(pend_valid), .ovf(ovf), .retire_cnt(retire_cnt)
    );

    // Architectural model: register contents, queue of parked writes (capacity 1), counters.
    logic [31:0] arch [32];
    typedef struct packed { logic [4:0] num; logic [31:0] data; } wr_t;
    wr_t         parked [$];
    bit          m_ovf;
    int unsigned m_retired;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] idx);
        if (idx == 0) return 32'h0;
`ifdef WB_BYPASS_EN
        if (reg_write_en && reg_write_num == idx) return reg_write_data;
`endif
        if (parked.size() != 0 && parked[0].num == idx) return parked[0].data;
        return arch[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) arch[i] = 32'h0;
        parked.delete();
        m_ovf = 0;
        m_retired = 0;
    endtask

    // One commit slot per edge: debug first, then the oldest parked write, then the live write.
    task automatic model_edge();
        bit  live;
        wr_t w;
        live = reg_write_en && reg_write_num != 0;
        w.num = reg_write_num;
        w.data = reg_write_data;
        if (dbg_wr) begin
            if (dbg_num != 0) arch[dbg_num] = dbg_data;
            if (live) begin
                if (parked.size() == 0) parked.push_back(w);
                else m_ovf = 1;
            end
        end else begin
            if (parked.size() != 0) begin
                wr_t p;
                p = parked.pop_front();
                arch[p.num] = p.data;
                m_retired++;
                if (live) parked.push_back(w);
            end else if (live) begin
                arch[w.num] = w.data;
                m_retired++;
            end
        end
    endtask

    task automatic drive(input bit dw, input logic [4:0] dn, input logic [31:0] dd,
                         input bit we, input logic [4:0] wn, input logic [31:0] wd,
                         input logic [4:0] rs, input logic [4:0] rt);
        dbg_wr = dw; dbg_num = dn; dbg_data = dd;
        reg_write_en = we; reg_write_num = wn; reg_write_data = wd;
        rs_num = rs; rt_num = rt;
    endtask

    // Called at negedge: check reads, clock once, check registered state; returns at next negedge.
    task automatic cycle(input bit dw, input logic [4:0] dn, input logic [31:0] dd,
                         input bit we, input logic [4:0] wn, input logic [31:0] wd,
                         input logic [4:0] rs, input logic [4:0] rt);
        logic [15:0] cnt_exp;
        drive(dw, dn, dd, we, wn, wd, rs, rt);
        #1;
        check("rs_data", rs_data, model_read(rs));
        check("rt_data", rt_data, model_read(rt));
        model_edge();
        @(posedge clk);
        #1;
        cnt_exp = m_retired[15:0];
        check("pend_valid", pend_valid, parked.size() != 0);
        check("ovf", ovf, m_ovf);
        check("retire_cnt", retire_cnt, cnt_exp);
        @(negedge clk);
    endtask

    task automatic peek(input logic [4:0] rs, input logic [4:0] rt);
        drive(0, 0, 0, 0, 0, 0, rs, rt);
        #1;
    endtask

    initial begin
        logic [31:0] byp_exp;
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 5'd5, 5'd0);
        clr_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_rs", rs_data, 32'h0);
        check("rst_pend", pend_valid, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_cnt", retire_cnt, 16'd0);
        clr_n = 1'b1;
        @(negedge clk);

        cycle(0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
        peek(5'd5, 5'd0);
        check("direct_r5", rs_data, 32'hDEADBEEF);
        check("direct_cnt", retire_cnt, 16'd1);

        cycle(0, 0, 0, 1, 5'd0, 32'h1234, 5'd0, 5'd0);
        peek(5'd0, 5'd0);
        check("r0_read", rs_data, 32'h0);
        check("r0_cnt", retire_cnt, 16'd1);

        cycle(1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 5'd3, 5'd4);
        peek(5'd3, 5'd4);
        check("coll_r3", rs_data, 32'h11);
        check("coll_pend", pend_valid, 1'b1);
        check("coll_r4", rt_data, 32'h22);
        cycle(0, 0, 0, 0, 0, 0, 5'd4, 5'd3);
        check("coll_drain", pend_valid, 1'b0);
        check("coll_cnt", retire_cnt, 16'd2);

        cycle(1, 5'd10, 32'h55, 1, 5'd6, 32'h1, 5'd6, 5'd7);
        cycle(1, 5'd11, 32'h66, 1, 5'd7, 32'h2, 5'd6, 5'd7);
        peek(5'd6, 5'd7);
        check("ovf_set", ovf, 1'b1);
        check("ovf_r6", rs_data, 32'h1);
        check("ovf_r7", rt_data, 32'h0);
        cycle(0, 0, 0, 0, 0, 0, 5'd6, 5'd7);
        check("ovf_cnt", retire_cnt, 16'd3);

`ifdef WB_BYPASS_EN
        byp_exp = 32'hA5;
`else
        byp_exp = 32'h0;
`endif
        drive(0, 0, 0, 1, 5'd9, 32'hA5, 5'd9, 5'd9);
        #1;
        check("bypass_r9", rs_data, byp_exp);
        cycle(0, 0, 0, 1, 5'd9, 32'hA5, 5'd9, 5'd9);
        peek(5'd9, 5'd0);
        check("bypass_next", rs_data, 32'hA5);

        for (int n = 0; n < 3000; n++) begin
            logic [4:0] a, b, c, d;
            a = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            b = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            c = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            d = 5'($urandom);
            cycle($urandom_range(0, 9) < 3, a, $urandom,
                  $urandom_range(0, 9) < 6, b, $urandom, c, d);
        end

        drive(0, 0, 0, 0, 0, 0, 5'd5, 5'd9);
        @(posedge clk);
        #3;
        clr_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_rs", rs_data, 32'h0);
        check("mid_rst_rt", rt_data, 32'h0);
        check("mid_rst_pend", pend_valid, 1'b0);
        check("mid_rst_ovf", ovf, 1'b0);
        check("mid_rst_cnt", retire_cnt, 16'd0);
        @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 200; n++) begin
            cycle($urandom_range(0, 9) < 3, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
